// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req           per-requester write request (held with stable data until acked)
//   req_data      requester i data in bits [i*DATA_W +: DATA_W]
//   ack           one-hot write acknowledge to the current owner
//   fifo_wr_enb   FIFO write enable (never asserted while fifo_full is high)
//   fifo_wr_data  FIFO write data, zero when not writing
//   fifo_full     FIFO full flag
//   grant_id      current owner, valid while busy
//   busy          high while a burst is granted
// Optional (macro FIFO_WR_ARBITER_STALL_CNT_EN):
//   stall_cnt     saturating count of cycles the owner was blocked by fifo_full
//   stall_clr     clears stall_cnt, wins over increment
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           ack,
    output logic                       fifo_wr_enb,
    output logic [DATA_W-1:0]          fifo_wr_data,
    input  logic                       fifo_full,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cnt,
    input  logic                       stall_clr
`endif
);
    localparam int GW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [GW-1:0]  r_grant;
    logic [GW-1:0]  r_last;
    logic [BW-1:0]  r_beat;
    logic [GW-1:0]  w_win;
    logic           w_owner_req;
    logic           w_write;
    logic           w_end;

    assign w_owner_req = req[r_grant];
    // Gated by rst so a burst interrupted by reset never writes in the reset cycle.
    assign w_write     = ~rst & (r_state == BURST) & w_owner_req & ~fifo_full;
    assign w_end       = (r_state == BURST) &
                         (~w_owner_req | (w_write & (r_beat == BW'(MAX_BURST - 1))));

    // Scan from last_grant+N down to last_grant+1 so the nearest requester wins.
    always_comb begin
        w_win = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req[GW'((int'(r_last) + i) % N_REQ)]) w_win = GW'((int'(r_last) + i) % N_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(N_REQ - 1);
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |req) begin
                r_grant <= w_win;
                r_beat  <= '0;
            end else if (w_end) begin
                r_last  <= r_grant;
                r_beat  <= '0;
            end else if (w_write) begin
                r_beat  <= r_beat + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = |req ? BURST : IDLE;
        else                 w_next = w_end ? IDLE : BURST;
    end

    always_comb begin
        ack          = w_write ? N_REQ'(1) << r_grant : '0;
        fifo_wr_enb  = w_write;
        fifo_wr_data = w_write ? req_data[r_grant*DATA_W +: DATA_W] : '0;
        grant_id     = r_grant;
        busy         = (r_state == BURST);
    end

`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || stall_clr)
            r_stall_cnt <= '0;
        else if (r_state == BURST && w_owner_req && fifo_full && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  d [4];
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        fifo_wr_enb;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic        stall_clr = 1'b0;
`endif
    int checks = 0;
    int errs = 0;

    assign req_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .fifo_wr_enb(fifo_wr_enb), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .stall_clr(stall_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Inputs are set before calling; outputs are combinational so allow them to settle.
    task automatic expect_out(input string tag, input logic [3:0] a, input logic [7:0] dt,
                              input logic b, input logic [1:0] g);
        #1;
        chk({tag, " ack"}, 32'(ack), 32'(a));
        chk({tag, " wr_enb"}, 32'(fifo_wr_enb), 32'(|a));
        chk({tag, " wr_data"}, 32'(fifo_wr_data), 32'(dt));
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " overrun"}, 32'(fifo_wr_enb & fifo_full), 32'(0));
        if (b) chk({tag, " grant_id"}, 32'(grant_id), 32'(g));
    endtask

    initial begin
        d[0] = 8'hA0; d[1] = 8'hB0; d[2] = 8'h21; d[3] = 8'hD0;
        // reset held with every requester asking
        cyc; req = 4'b1111;
        expect_out("rst1", 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc;
        expect_out("rst2", 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc; rst = 1'b0;
        expect_out("arb0", 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc;
        expect_out("first", 4'b0001, 8'hA0, 1'b1, 2'd0);
        cyc; req = 4'b0000;
        expect_out("rel0", 4'b0000, 8'h00, 1'b1, 2'd0);
        // single requester, three beats
        cyc; req = 4'b0100;
        expect_out("idle1", 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc;
        expect_out("r2b0", 4'b0100, 8'h21, 1'b1, 2'd2);
        cyc; d[2] = 8'h22;
        expect_out("r2b1", 4'b0100, 8'h22, 1'b1, 2'd2);
        cyc; d[2] = 8'h23;
        expect_out("r2b2", 4'b0100, 8'h23, 1'b1, 2'd2);
        cyc; req = 4'b0000;
        expect_out("r2rel", 4'b0000, 8'h00, 1'b1, 2'd2);
        // burst limit and rotation between 0 and 1
        cyc; req = 4'b0011; d[0] = 8'hA1; d[1] = 8'hB1;
        expect_out("idle2", 4'b0000, 8'h00, 1'b0, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc; d[0] = 8'(8'hA0 + i);
            expect_out("rot0", 4'b0001, 8'(8'hA0 + i), 1'b1, 2'd0);
        end
        cyc;
        expect_out("gap0", 4'b0000, 8'h00, 1'b0, 2'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc; d[1] = 8'(8'hB0 + i);
            expect_out("rot1", 4'b0010, 8'(8'hB0 + i), 1'b1, 2'd1);
        end
        cyc;
        expect_out("gap1", 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc; d[0] = 8'hA5;
        expect_out("back0", 4'b0001, 8'hA5, 1'b1, 2'd0);
        // full stall: three blocked cycles, then the held data goes through
        cyc; d[0] = 8'hA6; fifo_full = 1'b1;
        expect_out("stall1", 4'b0000, 8'h00, 1'b1, 2'd0);
        cyc;
        expect_out("stall2", 4'b0000, 8'h00, 1'b1, 2'd0);
        cyc;
        expect_out("stall3", 4'b0000, 8'h00, 1'b1, 2'd0);
        cyc; fifo_full = 1'b0;
        expect_out("unstall", 4'b0001, 8'hA6, 1'b1, 2'd0);
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd3);
`endif
        // owner releases in the same cycle the FIFO fills
        cyc; req = 4'b0010; fifo_full = 1'b1;
        expect_out("relfull", 4'b0000, 8'h00, 1'b1, 2'd0);
        cyc; req = 4'b1011; fifo_full = 1'b0; d[1] = 8'hB5;
        expect_out("relidle", 4'b0000, 8'h00, 1'b0, 2'd0);
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
        chk("stall_cnt_rel", 32'(stall_cnt), 32'd3);
`endif
        cyc;
        expect_out("after_rel", 4'b0010, 8'hB5, 1'b1, 2'd1);
        // requester 3 burst interrupted by reset at beat 2
        cyc; req = 4'b1000;
        expect_out("rel1", 4'b0000, 8'h00, 1'b1, 2'd1);
        cyc; d[3] = 8'hD1;
        expect_out("idle3", 4'b0000, 8'h00, 1'b0, 2'd0);
        cyc;
        expect_out("r3b0", 4'b1000, 8'hD1, 1'b1, 2'd3);
        cyc; d[3] = 8'hD2;
        expect_out("r3b1", 4'b1000, 8'hD2, 1'b1, 2'd3);
        cyc; d[3] = 8'hD3; rst = 1'b1; req = 4'b1001;
        expect_out("rstmid", 4'b0000, 8'h00, 1'b1, 2'd3);
        cyc; rst = 1'b0;
        expect_out("postrst", 4'b0000, 8'h00, 1'b0, 2'd0);
`ifdef FIFO_WR_ARBITER_STALL_CNT_EN
        chk("stall_cnt_rst", 32'(stall_cnt), 32'd0);
`endif
        cyc;
        expect_out("regrant0", 4'b0001, 8'hA6, 1'b1, 2'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
